vga_fifo_fill_ctrl: RTL and testbench
=====================================

// Module: vga_fifo_fill_ctrl
// PURPOSE
//  Write-side sequencer for the VGA async pixel FIFO. Issues fixed-length burst reads to the
//  frame-buffer read port and pushes the returned words into the FIFO source interface.
//  Credit-based: never requests more than the FIFO can absorb. Restarts the frame on frame_start.
//  Runs entirely in the FIFO source (memory) clock domain.
// PARAMETERS
//  DATA_WIDTH   32      pixel word width; equals FIFO data width
//  FIFO_DEPTH   16      depth of the driven FIFO
//  BURST_LEN    4       words per memory request; must divide FIFO_DEPTH and FRAME_WORDS
//  MADDR_WIDTH  24      frame-buffer word-address width
//  FRAME_WORDS  307200  words per frame (640x480, one pixel per word)
//  CNT_WIDTH    ceilLog2(FIFO_DEPTH+1), derived; FIFO count width
// PORTS
//  clk          in   1            source clock
//  rst_n        in   1            asynchronous active-low reset
//  enable       in   1            level; 0 = issue no new requests
//  frame_start  in   1            1-cycle pulse, already in clk domain; (re)start frame
//  base_addr    in   MADDR_WIDTH  frame base word address; sampled on frame_start only
//  mem_req      out  1            burst request valid
//  mem_addr     out  MADDR_WIDTH  burst start word address
//  mem_ack      in   1            request accepted (mem_req & mem_ack = handshake)
//  mem_rvld     in   1            read data beat valid (no back-pressure possible)
//  mem_rdata    in   DATA_WIDTH   read data beat
//  fifo_vld     out  1            to FIFO src_vld
//  fifo_rdy     in   1            from FIFO src_rdy
//  fifo_data    out  DATA_WIDTH   to FIFO src_data
//  fifo_cnt     in   CNT_WIDTH    from FIFO src_cnt (registered, pessimistic occupancy)
//  busy         out  1            state != IDLE/DONE or outstanding != 0
//  frame_done   out  1            1-cycle pulse when last burst of a frame is accepted
//  ovf_err      out  1            sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; mem_addr=0; outstanding=0; cur_addr=0; words_req=0.
//  Data path: 1-cycle register: fifo_vld<=mem_rvld, fifo_data<=mem_rdata (latency 1 cycle).
//  outstanding (width CNT_WIDTH+1): +BURST_LEN on mem handshake, -1 on fifo_vld&fifo_rdy;
//   both in the same cycle -> net +BURST_LEN-1.
//  space = FIFO_DEPTH - fifo_cnt - outstanding, computed signed; request allowed iff space>=BURST_LEN.
//   Hence fifo_cnt+outstanding <= FIFO_DEPTH at all times.
//  mem_req: asserted with mem_addr from the next cycle after the credit check passes.
//   Once asserted, mem_req and mem_addr are held stable until mem_ack.
//   mem_req is dropped only on handshake.
//  FSM:
//   IDLE : frame_start -> load cur_addr=base_addr, words_req=0 -> FILL.
//   FILL : enable & credit & !mem_req -> raise mem_req.
//          handshake -> cur_addr+=BURST_LEN (mod 2^MADDR_WIDTH), words_req+=BURST_LEN.
//          words_req reaches FRAME_WORDS -> pulse frame_done -> DONE.
//   DONE : frame_start -> reload base_addr -> FILL.
//   Any state: frame_start while FILL has words left -> DRAIN. This is an aborted frame:
//          a pending mem_req completes its handshake first; no new requests are made.
//   DRAIN: outstanding==0 -> reload base_addr latched at abort -> FILL.
//          Another frame_start in DRAIN re-latches base_addr.
//  enable=0: a pending mem_req still completes; returning data is still written; FSM holds.
//  mem_rvld is never refused: the credit scheme guarantees fifo_rdy whenever fifo_vld=1.
//  fifo_rdy=0 with fifo_vld=1 is an overflow: the beat is dropped and outstanding is not decremented.
//  Reset mid-burst: all state is cleared immediately; in-flight memory data after reset is
//   not counted (system resets memory port together).
// CONFIGURATION
//  VGA_FILL_OVF_CHK_EN defined: ovf_err set on fifo_vld&!fifo_rdy, cleared only by reset.
//   A 16-bit saturating drop counter is kept internally for debug visibility.
//  Not defined: ovf_err tied 0; the drop counter is absent.
// STRUCTURE
//  Shared package vga_ctrl_pkg:
//   - FSM state encoding (IDLE=2'd0, FILL=2'd1, DRAIN=2'd2, DONE=2'd3)
//   - ceilLog2 function
//   - default geometry constants (640, 480, FRAME_WORDS)
//  One sub-module, vga_fill_credit: the outstanding counter plus the space/credit compare,
//   with inputs req_hs, wr_hs, fifo_cnt and output credit_ok.
// TESTING
//  1 Reset, frame_start, base=0x100, mem_ack same cycle, fifo_cnt=0, no reads:
//    -> exactly 4 bursts at 0x100/0x104/0x108/0x10C, then mem_req stays 0 (16 words).
//  2 FIFO drains 1 word/cycle, FRAME_WORDS=32:
//    -> 8 bursts total, frame_done pulse on the 8th ack, state DONE, busy=0 once outstanding=0.
//  3 mem_ack delayed 5 cycles:
//    -> mem_req/mem_addr held constant for 5 cycles; exactly one burst counted.
//  4 frame_start mid-frame with outstanding=8, base=0x200:
//    -> no new req until 8 beats written, then the first req is at 0x200.
//  5 enable=0 during a pending req:
//    -> that req completes; no further req until enable=1; data beats still reach the FIFO.
//  6 With VGA_FILL_OVF_CHK_EN, force fifo_rdy=0 while mem_rvld=1:
//    -> ovf_err=1 next cycle and stays 1 until rst_n low.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the VGA memory-side controllers: fill FSM encoding,
// default frame geometry and a width helper.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;
  localparam int DEF_FRAME_WORDS = H_ACTIVE * V_ACTIVE;

  // Smallest w such that 2**w >= value.
  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_fill_credit.sv
// Tracks words requested from memory but not yet written into the FIFO, and
// grants a new burst only when the FIFO is guaranteed to have room for it.
module vga_fill_credit #(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_hs,
  input  logic                 wr_hs,
  input  logic [CNT_WIDTH-1:0] fifo_cnt,
  output logic [CNT_WIDTH:0]   outstanding,
  output logic                 credit_ok
);

  localparam int OW = CNT_WIDTH + 1;
  localparam int SW = CNT_WIDTH + 3;
  localparam logic [OW-1:0] BURST_INC = OW'(BURST_LEN);

  logic signed [SW-1:0] space;
  logic                 dec;

  // Beats arriving with nothing outstanding (e.g. stale data after reset) are not counted.
  assign dec = wr_hs && (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + (req_hs ? BURST_INC : '0) - {{CNT_WIDTH{1'b0}}, dec};
    end
  end

  assign space     = $signed(SW'(FIFO_DEPTH)) - $signed(SW'(fifo_cnt)) - $signed(SW'(outstanding));
  assign credit_ok = (space >= $signed(SW'(BURST_LEN)));

endmodule

// File: rtl/vga_fifo_fill_ctrl.sv
// Write-side sequencer for the VGA async pixel FIFO: credit-limited burst reads from the
// frame buffer pushed into the FIFO source port. Define VGA_FILL_OVF_CHK_EN for overflow tracking.
module vga_fifo_fill_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int BURST_LEN   = 4,
  parameter int MADDR_WIDTH = 24,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int CNT_WIDTH   = ceil_log2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic [MADDR_WIDTH-1:0] base_addr,
  output logic                   mem_req,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic                   mem_rvld,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   fifo_vld,
  input  logic                   fifo_rdy,
  output logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic [CNT_WIDTH-1:0]   fifo_cnt,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   ovf_err
);

  localparam int WR_WIDTH = ceil_log2(FRAME_WORDS + 1);
  localparam logic [WR_WIDTH-1:0]    FRAME_LEN    = WR_WIDTH'(FRAME_WORDS);
  localparam logic [WR_WIDTH-1:0]    BURST_WORDS  = WR_WIDTH'(BURST_LEN);
  localparam logic [MADDR_WIDTH-1:0] BURST_STRIDE = MADDR_WIDTH'(BURST_LEN);

  fill_state_t            state, state_next;
  logic [MADDR_WIDTH-1:0] cur_addr, pend_base;
  logic [WR_WIDTH-1:0]    words_req;
  logic [CNT_WIDTH:0]     outstanding;
  logic                   credit_ok, req_hs, wr_hs, last_burst;
  logic                   load_base, load_pend, latch_pend, raise_req, done_next;

  assign req_hs     = mem_req & mem_ack;
  assign wr_hs      = fifo_vld & fifo_rdy;
  assign last_burst = ((words_req + BURST_WORDS) == FRAME_LEN);
  assign busy       = (state == ST_FILL) || (state == ST_DRAIN) || (outstanding != '0);

  vga_fill_credit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BURST_LEN  (BURST_LEN),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_credit (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_hs      (req_hs),
    .wr_hs       (wr_hs),
    .fifo_cnt    (fifo_cnt),
    .outstanding (outstanding),
    .credit_ok   (credit_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // An abort in FILL takes priority over both completion and issuing a new burst.
  always_comb begin
    state_next = state;
    load_base  = 1'b0;
    load_pend  = 1'b0;
    latch_pend = 1'b0;
    raise_req  = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (frame_start) begin
          state_next = ST_FILL;
          load_base  = 1'b1;
        end
      end
      ST_FILL: begin
        if (frame_start) begin
          state_next = ST_DRAIN;
          latch_pend = 1'b1;
        end else if (req_hs && last_burst) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else if (enable && credit_ok && !mem_req) begin
          raise_req = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (frame_start) begin
          latch_pend = 1'b1;
        end else if ((outstanding == '0) && !mem_req) begin
          state_next = ST_FILL;
          load_pend  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      pend_base  <= '0;
      words_req  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_next;
      if (latch_pend) pend_base <= base_addr;
      if (load_base || load_pend) begin
        cur_addr  <= load_base ? base_addr : pend_base;
        words_req <= '0;
      end else if (req_hs && (state == ST_FILL)) begin
        cur_addr  <= cur_addr + BURST_STRIDE;
        words_req <= words_req + BURST_WORDS;
      end
      if (req_hs) begin
        mem_req <= 1'b0;
      end else if (raise_req) begin
        mem_req  <= 1'b1;
        mem_addr <= cur_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_vld  <= 1'b0;
      fifo_data <= '0;
    end else begin
      fifo_vld  <= mem_rvld;
      fifo_data <= mem_rdata;
    end
  end

`ifdef VGA_FILL_OVF_CHK_EN
  logic [15:0] drop_cnt;

  // A beat presented while the FIFO refuses it is lost; remember that it happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
    end else if (fifo_vld && !fifo_rdy) begin
      ovf_err <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fifo_fill_ctrl.sv
// Directed self-checking bench for vga_fifo_fill_ctrl with a small FIFO and memory
// responder model driven from the test thread; built with a 32-word frame.
module tb_vga_fifo_fill_ctrl;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int AW = 24;
  localparam int FW = 32;
  localparam int CW = 5;
`ifdef VGA_FILL_OVF_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable, frame_start, mem_req, mem_ack, mem_rvld;
  logic          fifo_vld, fifo_rdy, busy, frame_done, ovf_err;
  logic [AW-1:0] base_addr, mem_addr;
  logic [DW-1:0] mem_rdata, fifo_data;
  logic [CW-1:0] fifo_cnt;

  int checks = 0;
  int errors = 0;

  int            hs_count, wr_total, fd_cnt, fd_hs, beats_pending, req_age, occ, ack_delay;
  bit            ack_en, ret_en, drain_en;
  logic [AW-1:0] hs_addr [0:31];
  int            hs_wr   [0:31];
  logic [DW-1:0] next_data;
  logic [DW-1:0] data_q [$];

  always #5 clk = ~clk;

  vga_fifo_fill_ctrl #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (16),
    .BURST_LEN   (BL),
    .MADDR_WIDTH (AW),
    .FRAME_WORDS (FW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rvld    (mem_rvld),
    .mem_rdata   (mem_rdata),
    .fifo_vld    (fifo_vld),
    .fifo_rdy    (fifo_rdy),
    .fifo_data   (fifo_data),
    .fifo_cnt    (fifo_cnt),
    .busy        (busy),
    .frame_done  (frame_done),
    .ovf_err     (ovf_err)
  );

  // One clock: drive memory/FIFO responses at the negedge, log handshakes, advance the models.
  task automatic step();
    logic          hs, wr, rv, req_pre;
    logic [DW-1:0] exp_data;
    int            pre_occ;
    mem_ack   = ack_en && mem_req && (req_age >= ack_delay);
    mem_rvld  = ret_en && (beats_pending > 0);
    mem_rdata = next_data;
    req_pre   = mem_req;
    hs        = mem_req && mem_ack;
    wr        = fifo_vld && fifo_rdy;
    rv        = mem_rvld;
    if (fifo_vld) begin
      checks++;
      if (data_q.size() == 0) begin
        errors++; $display("[TB] FAIL data_spurious: fifo_data=%h presented, expected no beat", fifo_data);
      end else begin
        exp_data = data_q.pop_front();
        if (fifo_data !== exp_data) begin
          errors++; $display("[TB] FAIL data_path: fifo_data=%h, expected %h", fifo_data, exp_data);
        end
      end
    end
    if (hs) begin
      if (hs_count < 32) begin
        hs_addr[hs_count] = mem_addr;
        hs_wr[hs_count]   = wr_total;
      end
      hs_count++;
    end
    if (rv) data_q.push_back(next_data);
    @(posedge clk);
    @(negedge clk);
    if (hs) begin
      beats_pending += BL;
      req_age = 0;
    end else if (req_pre) begin
      req_age++;
    end
    if (rv) begin
      beats_pending--;
      next_data = next_data + 32'h0101_0101;
    end
    if (wr) wr_total++;
    pre_occ = occ;
    if (wr) occ++;
    if (drain_en && pre_occ > 0) occ--;
    fifo_cnt = CW'(occ);
    if (frame_done) begin
      fd_cnt++;
      fd_hs = hs_count;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; base_addr = '0;
    mem_ack = 1'b0; mem_rvld = 1'b0; mem_rdata = '0; fifo_rdy = 1'b1; fifo_cnt = '0;
    hs_count = 0; wr_total = 0; fd_cnt = 0; fd_hs = 0; beats_pending = 0; req_age = 0; occ = 0;
    ack_delay = 0; ack_en = 1'b1; ret_en = 1'b0; drain_en = 1'b0;
    next_data = 32'hA000_0001;
    data_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_frame(input logic [AW-1:0] base);
    base_addr   = base;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %b, expected 0", mem_req); end
    checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h, expected 0", mem_addr); end
    checks++; if (fifo_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_fifo_vld: got %b, expected 0", fifo_vld); end
    checks++; if (fifo_data !== '0) begin errors++; $display("[TB] FAIL rst_fifo_data: got %h, expected 0", fifo_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done: got %b, expected 0", frame_done); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf_err: got %b, expected 0", ovf_err); end
    // Asynchronous reset while a request is pending.
    ack_en = 1'b0; enable = 1'b1;
    pulse_frame(24'h000100);
    repeat (3) step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_req: got %b, expected 1", mem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_req: got %b, expected 0", mem_req); end
    checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL async_rst_addr: got %h, expected 0", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_credit_fill();
    do_reset();
    enable = 1'b1;
    pulse_frame(24'h000100);
    repeat (30) step();
    checks++; if (hs_count != 4) begin errors++; $display("[TB] FAIL credit_bursts: got %0d, expected 4", hs_count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hs_addr[i] !== AW'(24'h000100 + 4 * i)) begin
        errors++; $display("[TB] FAIL credit_addr%0d: got %h, expected %h", i, hs_addr[i], AW'(24'h000100 + 4 * i));
      end
    end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL credit_req_idle: got %b, expected 0", mem_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL credit_busy: got %b, expected 1", busy); end
  endtask

  task automatic test_frame_done();
    int n;
    do_reset();
    enable = 1'b1; ret_en = 1'b1; drain_en = 1'b1;
    pulse_frame(24'h000000);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_idle_timeout: busy=%b after %0d cycles, expected 0", busy, n); end
    checks++; if (hs_count != 8) begin errors++; $display("[TB] FAIL frame_bursts: got %0d, expected 8", hs_count); end
    checks++; if (hs_addr[7] !== 24'h00001C) begin errors++; $display("[TB] FAIL frame_last_addr: got %h, expected 00001c", hs_addr[7]); end
    checks++; if (fd_cnt != 1) begin errors++; $display("[TB] FAIL frame_done_pulses: got %0d, expected 1", fd_cnt); end
    checks++; if (fd_hs != 8) begin errors++; $display("[TB] FAIL frame_done_timing: after burst %0d, expected 8", fd_hs); end
    checks++; if (wr_total != FW) begin errors++; $display("[TB] FAIL frame_words: got %0d, expected %0d", wr_total, FW); end
    repeat (20) step();
    checks++; if (hs_count != 8) begin errors++; $display("[TB] FAIL done_no_req: bursts %0d, expected 8", hs_count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL done_req: got %b, expected 0", mem_req); end
  endtask

  task automatic test_ack_delay();
    int n;
    do_reset();
    enable = 1'b1; ack_delay = 5;
    pulse_frame(24'h000040);
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL delay_req_timeout: mem_req=%b, expected 1", mem_req); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 24'h000040 || hs_count != 0) begin
        errors++; $display("[TB] FAIL delay_hold%0d: req=%b addr=%h bursts=%0d, expected 1/000040/0", i, mem_req, mem_addr, hs_count);
      end
      step();
    end
    step();
    checks++; if (hs_count != 1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL delay_single: bursts=%0d req=%b, expected 1/0", hs_count, mem_req); end
    ack_delay = 0;
    repeat (30) step();
    checks++; if (hs_count != 4) begin errors++; $display("[TB] FAIL delay_credit: bursts %0d, expected 4", hs_count); end
    checks++; if (hs_addr[3] !== 24'h00004C) begin errors++; $display("[TB] FAIL delay_addr3: got %h, expected 00004c", hs_addr[3]); end
  endtask

  task automatic run_abort(input logic [AW-1:0] base_a, input logic [AW-1:0] base_b, input bit relatch);
    int            n;
    logic [AW-1:0] exp_addr;
    exp_addr = relatch ? base_b : base_a;
    do_reset();
    enable = 1'b1;
    pulse_frame(24'h000000);
    n = 0;
    while (hs_count < 2 && n < 20) begin
      step();
      n++;
    end
    pulse_frame(base_a);
    repeat (4) step();
    if (relatch) pulse_frame(base_b);
    repeat (6) step();
    checks++; if (hs_count != 2 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_hold: bursts=%0d req=%b, expected 2/0", hs_count, mem_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy: got %b, expected 1", busy); end
    ret_en = 1'b1;
    n = 0;
    while (hs_count < 3 && n < 40) begin
      step();
      n++;
    end
    checks++; if (hs_count < 3) begin errors++; $display("[TB] FAIL abort_restart_timeout: bursts=%0d, expected 3", hs_count); end
    checks++; if (hs_addr[2] !== exp_addr) begin errors++; $display("[TB] FAIL abort_addr: got %h, expected %h", hs_addr[2], exp_addr); end
    checks++; if (hs_wr[2] != 8) begin errors++; $display("[TB] FAIL abort_drained: %0d words written before restart, expected 8", hs_wr[2]); end
  endtask

  task automatic test_abort();
    run_abort(24'h000200, 24'h000000, 1'b0);
    run_abort(24'h000500, 24'h000600, 1'b1);
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    enable = 1'b1; ack_delay = 3;
    pulse_frame(24'h000300);
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    enable = 1'b0;
    repeat (4) step();
    checks++; if (hs_count != 1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL en_pending: bursts=%0d req=%b, expected 1/0", hs_count, mem_req); end
    ret_en = 1'b1; drain_en = 1'b1; ack_delay = 0;
    repeat (15) step();
    checks++; if (hs_count != 1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL en_hold: bursts=%0d req=%b, expected 1/0", hs_count, mem_req); end
    checks++; if (wr_total != 4) begin errors++; $display("[TB] FAIL en_data: %0d words written, expected 4", wr_total); end
    enable = 1'b1;
    n = 0;
    while (hs_count < 2 && n < 10) begin
      step();
      n++;
    end
    checks++; if (hs_count < 2) begin errors++; $display("[TB] FAIL en_resume_timeout: bursts=%0d, expected 2", hs_count); end
    checks++; if (hs_addr[1] !== 24'h000304) begin errors++; $display("[TB] FAIL en_resume_addr: got %h, expected 000304", hs_addr[1]); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    enable = 1'b1; ret_en = 1'b1; fifo_rdy = 1'b0;
    pulse_frame(24'h000000);
    n = 0;
    while (fifo_vld !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++; if (fifo_vld !== 1'b1) begin errors++; $display("[TB] FAIL ovf_vld_timeout: fifo_vld=%b, expected 1", fifo_vld); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b, expected 0", ovf_err); end
    step();
    checks++; if (ovf_err !== OVF_EXP) begin errors++; $display("[TB] FAIL ovf_set: got %b, expected %b", ovf_err, OVF_EXP); end
    fifo_rdy = 1'b1;
    repeat (10) step();
    checks++; if (ovf_err !== OVF_EXP) begin errors++; $display("[TB] FAIL ovf_sticky: got %b, expected %b", ovf_err, OVF_EXP); end
    rst_n = 1'b0;
    #1;
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b, expected 0", ovf_err); end
    do_reset();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_credit_fill();
    test_frame_done();
    test_ack_delay();
    test_abort();
    test_enable();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
